// File: rtl/timer_pkg.sv
// Shared constants and helpers for the TIMA/TMA/TAC timer block.
package timer_pkg;

  // Register offsets inside the FF04-FF07 window, expressed as {A1,A0}.
  localparam logic [1:0] REG_DIV  = 2'b00;
  localparam logic [1:0] REG_TIMA = 2'b01;
  localparam logic [1:0] REG_TMA  = 2'b10;
  localparam logic [1:0] REG_TAC  = 2'b11;

  // TAC[1:0] clock select encodings.
  localparam logic [1:0] TAC_SEL_4096   = 2'b00;
  localparam logic [1:0] TAC_SEL_262144 = 2'b01;
  localparam logic [1:0] TAC_SEL_65536  = 2'b10;
  localparam logic [1:0] TAC_SEL_16384  = 2'b11;

  // Unimplemented TAC bits read back as ones.
  localparam logic [7:0] TAC_RD_PAD = 8'hF8;

  // Register offset recovered from the inverted address lines.
  function automatic logic [1:0] reg_offset(input logic na1, input logic na0);
    return {~na1, ~na0};
  endfunction

  // Bus image of TAC.
  function automatic logic [7:0] tac_read(input logic [2:0] tac);
    return TAC_RD_PAD | {5'b00000, tac};
  endfunction

endpackage

// File: rtl/timer_tap_sel.sv
// Divider tap selection and falling-edge detector that produces the TIMA
// increment strobe. A drop of the gated tap for any reason (tap edge, TAC
// write, enable cleared, divider reset) counts, as on the original silicon.
module timer_tap_sel
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] tac,
  input  logic       tap_4096,
  input  logic       tap_16384,
  input  logic       tap_65536,
  input  logic       tap_262144,
  output logic       inc
);

  logic tap_mux;
  logic sel;
  logic sel_q;

  // Pick the divider tap named by TAC[1:0].
  always_comb begin
    tap_mux = tap_4096;
    case (tac[1:0])
      TAC_SEL_4096:   tap_mux = tap_4096;
      TAC_SEL_262144: tap_mux = tap_262144;
      TAC_SEL_65536:  tap_mux = tap_65536;
      TAC_SEL_16384:  tap_mux = tap_16384;
      default:        tap_mux = tap_4096;
    endcase
  end

  assign sel = tap_mux & tac[2];

  // Remember the previous gated tap for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= 1'b0;
    else       sel_q <= sel;
  end

  assign inc = sel_q & ~sel;

endmodule

// File: rtl/timer_tima.sv
// Programmable timer: TIMA counter, TMA reload value, TAC control.
// Counts falling edges of the selected divider tap; on overflow TIMA shows
// 00 for one cycle, then loads TMA while raising a one-cycle interrupt.
module timer_tima
  import timer_pkg::*;
#(
  parameter logic [2:0] TAC_RESET = 3'b000
) (
  input  logic       boga1mhz,
  input  logic       reset,
  input  logic       ff04_ff07,
  input  logic       tola_na1,
  input  logic       tovy_na0,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  inout  wire  [7:0] d,
  input  logic       _4096hz,
  input  logic       _16384hz,
  input  logic       _65536hz,
  input  logic       _262144hz,
  output logic       int_timer
);

  logic [7:0] tima;
  logic [7:0] tma;
  logic [2:0] tac;
  logic       ovf;
  logic       inc;

  logic [1:0] ofs;
  logic       hit_tima;
  logic       hit_tma;
  logic       hit_tac;
  logic       wr_tima;
  logic       wr_tma;
  logic       wr_tac;
  logic       rd_en;
  logic [7:0] rd_data;

  assign ofs      = reg_offset(tola_na1, tovy_na0);
  assign hit_tima = ff04_ff07 & (ofs == REG_TIMA);
  assign hit_tma  = ff04_ff07 & (ofs == REG_TMA);
  assign hit_tac  = ff04_ff07 & (ofs == REG_TAC);
  assign wr_tima  = cpu_wr & hit_tima;
  assign wr_tma   = cpu_wr & hit_tma;
  assign wr_tac   = cpu_wr & hit_tac;

  timer_tap_sel u_tap_sel (
    .clk        (boga1mhz),
    .reset      (reset),
    .tac        (tac),
    .tap_4096   (_4096hz),
    .tap_16384  (_16384hz),
    .tap_65536  (_65536hz),
    .tap_262144 (_262144hz),
    .inc        (inc)
  );

  // TAC and TMA are plain CPU-written registers.
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tac <= TAC_RESET;
      tma <= 8'h00;
    end else begin
      if (wr_tac) tac <= d[2:0];
      if (wr_tma) tma <= d;
    end
  end

  // TIMA with overflow/reload sequencing. int_timer high marks the reload
  // cycle, during which TIMA keeps following TMA (including a same-cycle
  // TMA write) and ignores both CPU writes and increments.
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tima      <= 8'h00;
      ovf       <= 1'b0;
      int_timer <= 1'b0;
    end else begin
      ovf       <= 1'b0;
      int_timer <= 1'b0;
      if (int_timer) begin
        tima <= wr_tma ? d : tma;
      end else if (wr_tima) begin
        tima <= d;
      end else if (ovf) begin
        tima      <= tma;
        int_timer <= 1'b1;
      end else if (inc) begin
        tima <= tima + 8'h01;
        ovf  <= (tima == 8'hFF);
      end
    end
  end

  // Read mux for the three registers owned by this block; FF04 is left alone.
  always_comb begin
    rd_en   = cpu_rd & (hit_tima | hit_tma | hit_tac);
    rd_data = 8'h00;
    if (hit_tima)     rd_data = tima;
    else if (hit_tma) rd_data = tma;
    else if (hit_tac) rd_data = tac_read(tac);
  end

  assign d = rd_en ? rd_data : {8{1'bz}};

endmodule

// File: tb/tb_timer_tima.sv
// Self-checking bench for timer_tima: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the timer.
module tb_timer_tima;

  logic       clk = 1'b0;
  logic       rst;
  logic       ff, na1, na0, wr, rd;
  logic       t4096, t16384, t65536, t262144;
  logic [7:0] tb_d;
  logic       tb_oe;
  wire  [7:0] d;
  wire        int_timer;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = counting, 1 = overflowed (TIMA 00), 2 = reload/irq.
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  logic       m_selq;
  int         m_phase;

  always #5 clk = ~clk;

  assign d = tb_oe ? tb_d : 8'bz;
  pullup (d);

  timer_tima #(.TAC_RESET(3'b000)) dut (
    .boga1mhz  (clk),
    .reset     (rst),
    .ff04_ff07 (ff),
    .tola_na1  (na1),
    .tovy_na0  (na0),
    .cpu_wr    (wr),
    .cpu_rd    (rd),
    .d         (d),
    ._4096hz   (t4096),
    ._16384hz  (t16384),
    ._65536hz  (t65536),
    ._262144hz (t262144),
    .int_timer (int_timer)
  );

  task automatic model_reset();
    m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000; m_selq = 1'b0; m_phase = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    if (a == 2'd1)      return m_tima;
    else if (a == 2'd2) return m_tma;
    else                return {5'b11111, m_tac};
  endfunction

  // Expected bus value: a register image on timer reads, pulled-up float otherwise.
  function automatic logic [7:0] exp_bus();
    logic [1:0] a;
    a = {~na1, ~na0};
    if (rd && ff && a != 2'd0) return model_read(a);
    return 8'hFF;
  endfunction

  // Advance the model across one rising edge using the inputs held in that cycle.
  task automatic model_step();
    logic [1:0] a;
    logic       w05, w06, w07, tapv, sel, inc;
    logic [7:0] n_tima;
    int         n_ph;
    if (rst) begin
      model_reset();
      return;
    end
    a   = {~na1, ~na0};
    w05 = wr && ff && a == 2'd1;
    w06 = wr && ff && a == 2'd2;
    w07 = wr && ff && a == 2'd3;
    case (m_tac[1:0])
      2'd0: tapv = t4096;
      2'd1: tapv = t262144;
      2'd2: tapv = t65536;
      default: tapv = t16384;
    endcase
    sel    = m_tac[2] & tapv;
    inc    = m_selq & !sel;
    m_selq = sel;
    n_tima = m_tima;
    n_ph   = 0;
    if (m_phase == 2) begin
      n_tima = w06 ? tb_d : m_tma;
    end else if (m_phase == 1) begin
      if (w05) n_tima = tb_d;
      else begin
        n_tima = m_tma;
        n_ph   = 2;
      end
    end else if (w05) begin
      n_tima = tb_d;
    end else if (inc) begin
      n_tima = (m_tima + 1) % 256;
      if (m_tima == 8'hFF) n_ph = 1;
    end
    m_tima  = n_tima;
    m_phase = n_ph;
    if (w06) m_tma = tb_d;
    if (w07) m_tac = tb_d[2:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    ff = 1'b1; na1 = ~a[1]; na0 = ~a[0]; rd = 1'b0;
    wr = 1'b1; tb_oe = 1'b1; tb_d = v;
    tick();
    wr = 1'b0; tb_oe = 1'b0; ff = 1'b0;
  endtask

  task automatic read_lit(input logic [1:0] a, input logic [7:0] exp, input string name);
    ff = 1'b1; na1 = ~a[1]; na0 = ~a[0]; rd = 1'b1;
    #2;
    chk(name, d, exp);
    rd = 1'b0; ff = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    checks++;
    if (int_timer !== (m_phase == 2)) begin
      errors++;
      $display("FAIL int_timer: got %b expected %b at %0t", int_timer, (m_phase == 2), $time);
    end
    if (!tb_oe) begin
      checks++;
      if (d !== exp_bus()) begin
        errors++;
        $display("FAIL bus_d: got %h expected %h at %0t", d, exp_bus(), $time);
      end
    end
  end

  initial begin
    rst = 1'b1; ff = 1'b0; na1 = 1'b1; na0 = 1'b1; wr = 1'b0; rd = 1'b0;
    t4096 = 1'b0; t16384 = 1'b0; t65536 = 1'b0; t262144 = 1'b0;
    tb_d = 8'h00; tb_oe = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    read_lit(2'd1, 8'h00, "rst_tima");
    read_lit(2'd2, 8'h00, "rst_tma");
    read_lit(2'd3, 8'hF8, "rst_tac");
    chk("rst_int", {7'b0, int_timer}, 8'h00);

    // Count FC -> 00 on the 262144 Hz tap, then reload and interrupt.
    bus_write(2'd3, 8'h05);
    bus_write(2'd2, 8'h00);
    bus_write(2'd1, 8'hFC);
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    read_lit(2'd1, 8'hFD, "cnt_fd");
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    read_lit(2'd1, 8'hFE, "cnt_fe");
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    read_lit(2'd1, 8'hFF, "cnt_ff");
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    read_lit(2'd1, 8'h00, "cnt_wrap");
    chk("ovf_no_int_yet", {7'b0, int_timer}, 8'h00);
    tick();
    read_lit(2'd1, 8'h00, "reload_tma00");
    chk("int_pulse", {7'b0, int_timer}, 8'h01);
    tick();
    chk("int_clear", {7'b0, int_timer}, 8'h00);

    // TIMA write in the overflowed cycle cancels reload and interrupt.
    bus_write(2'd2, 8'hA5);
    bus_write(2'd1, 8'hFF);
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    bus_write(2'd1, 8'h33);
    read_lit(2'd1, 8'h33, "cancel_tima");
    chk("cancel_int0", {7'b0, int_timer}, 8'h00);
    tick();
    chk("cancel_int1", {7'b0, int_timer}, 8'h00);
    read_lit(2'd1, 8'h33, "cancel_tima_hold");

    // TMA write during the reload cycle lands in TIMA.
    bus_write(2'd1, 8'hFF);
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    tick();
    read_lit(2'd1, 8'hA5, "reload_a5");
    chk("reload_int", {7'b0, int_timer}, 8'h01);
    bus_write(2'd2, 8'h5A);
    read_lit(2'd1, 8'h5A, "reload_new_tma");
    read_lit(2'd2, 8'h5A, "tma_5a");

    // Glitch increments from TAC changes.
    t4096 = 1'b1; t262144 = 1'b0;
    bus_write(2'd3, 8'h04);
    bus_write(2'd1, 8'h10);
    bus_write(2'd3, 8'h05);
    tick();
    read_lit(2'd1, 8'h11, "glitch_tac_sel");
    t262144 = 1'b1; tick();
    bus_write(2'd3, 8'h00);
    tick();
    read_lit(2'd1, 8'h12, "glitch_enable_drop");

    // Read decode.
    t4096 = 1'b0; t262144 = 1'b0;
    bus_write(2'd3, 8'h06);
    read_lit(2'd3, 8'hFE, "rd_tac_110");
    bus_write(2'd1, 8'h7E);
    read_lit(2'd1, 8'h7E, "rd_tima_7e");
    ff = 1'b1; na1 = 1'b1; na0 = 1'b0; rd = 1'b0; #2;
    chk("no_rd_float", d, 8'hFF);
    ff = 1'b0;
    read_lit(2'd0, 8'hFF, "ff04_float");

    // Reset while the reload is pending.
    bus_write(2'd3, 8'h05);
    bus_write(2'd2, 8'h44);
    bus_write(2'd1, 8'hFF);
    t262144 = 1'b1; tick(); t262144 = 1'b0; tick();
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0;
    chk("rst_mid_int", {7'b0, int_timer}, 8'h00);
    tick();
    chk("rst_after_int", {7'b0, int_timer}, 8'h00);
    read_lit(2'd1, 8'h00, "rst_mid_tima");
    read_lit(2'd3, 8'hF8, "rst_mid_tac");

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      int op;
      logic [1:0] a;
      logic [7:0] v;
      if ($urandom_range(0, 3) == 0) t4096    = ~t4096;
      if ($urandom_range(0, 3) == 0) t16384   = ~t16384;
      if ($urandom_range(0, 2) == 0) t65536   = ~t65536;
      if ($urandom_range(0, 1) == 0) t262144  = ~t262144;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; model_reset();
        tick();
        rst = 1'b0;
      end
      op = $urandom_range(0, 15);
      if (op == 0) begin
        v = ($urandom_range(0, 1) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
        bus_write(2'd1, v);
      end else if (op == 1) begin
        bus_write(2'd2, 8'($urandom));
      end else if (op == 2) begin
        v = 8'($urandom);
        if ($urandom_range(0, 3) != 0) v[2] = 1'b1;
        bus_write(2'd3, v);
      end else if (op == 3) begin
        bus_write(2'd0, 8'($urandom));
      end else begin
        a   = 2'($urandom);
        ff  = ($urandom_range(0, 7) != 0);
        na1 = ~a[1]; na0 = ~a[0];
        rd  = ($urandom_range(0, 3) != 0);
        tick();
        rd = 1'b0; ff = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
